// File: rtl/mux_alu_pipe.sv
// Two-stage operand-select + ALU pipeline with valid/ready on both sides.
// Stage 1 latches the selected operands, stage 2 latches the WIDTH+1-bit result.
module mux_alu_pipe #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]        sel_a,
  input  logic [SEL_W-1:0]        sel_b,
  input  logic [2:0]              op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH:0]          out,
  output logic [CNT_W-1:0]        txn_count
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_PASS = 3'd5;
  localparam logic [2:0] OP_INC  = 3'd6;
  localparam logic [2:0] OP_LTU  = 3'd7;

  logic [WIDTH-1:0] operand [N_IN];

  logic             s1_valid_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       op_reg;

  logic             out_valid_reg;
  logic [WIDTH:0]   out_reg;
  logic [CNT_W-1:0] txn_count_reg;

  logic             s1_ready;
  logic             s2_ready;
  logic [WIDTH:0]   result_next;
  logic [WIDTH:0]   x;
  logic [WIDTH:0]   y;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_unpack
      assign operand[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Ready depends only on registered state and out_ready, never on in_valid.
  assign s2_ready  = !out_valid_reg || out_ready;
  assign s1_ready  = !s1_valid_reg || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign txn_count = txn_count_reg;

  assign x = {1'b0, a_reg};
  assign y = {1'b0, b_reg};

  always_comb begin
    result_next = '0;
    case (op_reg)
      OP_ADD:  result_next = x + y;
      OP_SUB:  result_next = x - y;
      OP_AND:  result_next = {1'b0, a_reg & b_reg};
      OP_OR:   result_next = {1'b0, a_reg | b_reg};
      OP_XOR:  result_next = {1'b0, a_reg ^ b_reg};
      OP_PASS: result_next = x;
      OP_INC:  result_next = x + (WIDTH+1)'(1);
      OP_LTU:  result_next = (WIDTH+1)'(a_reg < b_reg);
      default: result_next = '0;
    endcase
  end

  // Operand/op capture is gated by the input handshake only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_valid && s1_ready) begin
      a_reg  <= operand[sel_a];
      b_reg  <= operand[sel_b];
      op_reg <= op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      txn_count_reg <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid_reg <= in_valid;
      end
      if (s2_ready) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_reg <= result_next;
        end
      end
      if (out_valid_reg && out_ready) begin
        txn_count_reg <= txn_count_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_alu_pipe.sv
// Directed bench for mux_alu_pipe: a scoreboard queue filled on input handshakes
// and drained by a negedge monitor on output handshakes.
module tb_mux_alu_pipe;
  localparam int W = 32;
  localparam int N = 4;
  localparam int C = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] in_data = '0;
  logic [1:0]     sel_a = '0;
  logic [1:0]     sel_b = '0;
  logic [2:0]     op = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W:0]     out;
  logic [C-1:0]   txn_count;

  int errors = 0;
  int checks = 0;

  logic [W:0]   q[$];
  logic [W:0]   cur_exp;
  logic [W-1:0] opnd [N];
  logic [C-1:0] exp_cnt = '0;
  logic         prev_stall = 1'b0;
  logic [W:0]   prev_out = '0;

  logic [2:0]   tp_op [4];
  logic [1:0]   tp_sa [4];
  logic [1:0]   tp_sb [4];

  mux_alu_pipe #(.WIDTH(W), .N_IN(N), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sel_a(sel_a), .sel_b(sel_b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] s;
    case (o)
      3'd0: begin s = 64'(a) + 64'(b); return s[W:0]; end
      3'd1: return {(a < b), a - b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, a};
      3'd6: return (a == {W{1'b1}}) ? {1'b1, {W{1'b0}}} : {1'b0, a + W'(1)};
      default: return (W+1)'(a < b);
    endcase
  endfunction

  task automatic drive(input logic [2:0] o, input logic [1:0] sa, input logic [1:0] sb);
    for (int k = 0; k < N; k++) in_data[k*W +: W] = opnd[k];
    op = o; sel_a = sa; sel_b = sb; in_valid = 1'b1;
    cur_exp = model(o, opnd[sa], opnd[sb]);
  endtask

  task automatic wait_accept();
    logic acc;
    bit done;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin q.push_back(cur_exp); done = 1; end
    end
    if (!done) check("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
  endtask

  // Single transaction through an empty pipeline, with latency and value check.
  task automatic single(input string tag, input logic [2:0] o, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [W:0] want);
    drive(o, sa, sb);
    wait_accept();
    in_valid = 1'b0;
    @(negedge clk); check({tag, "_lat1"}, out_valid, 1'b0);
    @(negedge clk); check({tag, "_lat2"}, out_valid, 1'b1);
    check({tag, "_out"}, out, want);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else begin
      check("ctl_known", (W+1)'($isunknown({out_valid, in_ready, txn_count})), '0);
      check("txn_count", (W+1)'(txn_count), (W+1)'(exp_cnt));
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_out", out, prev_out);
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", (W+1)'(q.size() != 0), 1);
        if (q.size() != 0) check("sb_out", out, q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    opnd[0] = 32'hFFFF_FFFF; opnd[1] = 32'd1; opnd[2] = 32'd5; opnd[3] = 32'd7;
    tp_op[0] = 3'd0; tp_sa[0] = 2'd0; tp_sb[0] = 2'd1;
    tp_op[1] = 3'd2; tp_sa[1] = 2'd0; tp_sb[1] = 2'd1;
    tp_op[2] = 3'd4; tp_sa[2] = 2'd2; tp_sb[2] = 2'd2;
    tp_op[3] = 3'd6; tp_sa[3] = 2'd0; tp_sb[3] = 2'd0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, '0);
    check("rst_txn", (W+1)'(txn_count), '0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Carry, borrow, compare
    out_ready = 1'b1;
    single("carry", 3'd0, 2'd0, 2'd1, 33'h1_0000_0000);
    @(negedge clk); check("carry_txn", (W+1)'(txn_count), 1);
    @(posedge clk); #1;
    single("sub", 3'd1, 2'd2, 2'd3, 33'h1_FFFF_FFFE);
    single("ltu", 3'd7, 2'd2, 2'd3, 33'h0_0000_0001);
    single("ltu_swap", 3'd7, 2'd3, 2'd2, 33'h0_0000_0000);
    single("alias_or", 3'd3, 2'd3, 2'd3, 33'h0_0000_0007);

    // Throughput: four back-to-back transfers
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(tp_op[i], tp_sa[i], tp_sb[i]);
      @(negedge clk);
      check("tp_in_ready", in_ready, 1'b1);
      check("tp_out_valid", out_valid, (i >= 2));
      @(posedge clk); #1;
      q.push_back(cur_exp);
    end
    in_valid = 1'b0;
    @(negedge clk); check("tp_out_valid4", out_valid, 1'b1);
    @(negedge clk); check("tp_out_valid5", out_valid, 1'b1);
    check("tp_inc_out", out, 33'h1_0000_0000);
    @(negedge clk); check("tp_out_valid6", out_valid, 1'b0);
    check("tp_txn", (W+1)'(txn_count), 4);
    @(posedge clk); #1;

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    drive(3'd0, 2'd0, 2'd1); wait_accept();
    drive(3'd1, 2'd2, 2'd3); wait_accept();
    drive(3'd3, 2'd1, 2'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_hold_out", out, 33'h1_0000_0000);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("bp_txn", (W+1)'(txn_count), 3);
    check("bp_drained", (W+1)'(q.size()), 0);
    @(posedge clk); #1;

    // Reset with both stages occupied
    do_reset();
    out_ready = 1'b0;
    drive(3'd0, 2'd0, 2'd1); wait_accept();
    drive(3'd2, 2'd0, 2'd1); wait_accept();
    in_valid = 1'b0;
    @(negedge clk); check("mid_pre_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_out_valid", out_valid, 1'b0);
    check("mid_out", out, '0);
    check("mid_txn", (W+1)'(txn_count), 0);
    check("mid_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("mid_no_stale", out_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Counter wrap via 65536 PASS transfers
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      opnd[0] = W'(i);
      drive(3'd5, 2'd0, 2'd1);
      wait_accept();
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("wrap_zero", (W+1)'(txn_count), 0);
    @(posedge clk); #1;
    opnd[0] = 32'hA5A5_0001;
    single("wrap_next", 3'd5, 2'd0, 2'd1, 33'h0_A5A5_0001);
    @(negedge clk); check("wrap_one", (W+1)'(txn_count), 1);

    check("sb_drained", (W+1)'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
